// File: rtl/dds_pwm_dac.sv
// Sine-sample to complementary PWM output stage with dead time.
// Samples are double-buffered and applied only at PWM period boundaries.
module dds_pwm_dac #(
  parameter int DW   = 20,
  parameter int PW   = 8,
  parameter int DEAD = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  output logic          sample_taken,
  output logic          overrun,
  output logic          period_start,
  output logic          pwm_hi,
  output logic          pwm_lo
);

  localparam int DCW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic [DCW-1:0] DEAD_C  = DCW'(DEAD);
  localparam logic [PW-1:0]  CNT_MAX = '1;
  localparam logic [PW-1:0]  MID     = {1'b1, {(PW-1){1'b0}}};

  logic [PW-1:0] cnt_reg;
  logic [PW-1:0] active_reg;
  logic [PW-1:0] shadow_reg;
  logic          pending_reg;
  logic          taken_reg;
  logic          overrun_reg;
  logic          period_start_reg;

  logic [PW-1:0] duty_new;
  logic          transfer;
  logic          raw;
  logic [1:0]    drive;
  logic [1:0]    out_vec;

  // Offset-binary conversion: flip the sign bit, keep the top PW bits, truncate the rest.
  assign duty_new = {~sample_in[DW-1], sample_in[DW-2 -: PW-1]};
  assign transfer = (cnt_reg == CNT_MAX) && pending_reg;
  assign raw      = (cnt_reg < active_reg);
  assign drive    = {~raw & enable, raw & enable};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg          <= '0;
      active_reg       <= MID;
      shadow_reg       <= MID;
      pending_reg      <= 1'b0;
      taken_reg        <= 1'b0;
      overrun_reg      <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= enable ? cnt_reg + 1'b1 : '0;
      period_start_reg <= enable && (cnt_reg == '0);
      taken_reg        <= transfer;
      // A valid coinciding with a transfer refills the shadow, so it is not an overrun.
      overrun_reg      <= sample_valid && pending_reg && !transfer;
      pending_reg      <= sample_valid || (pending_reg && !transfer);
      if (transfer) begin
        active_reg <= shadow_reg;
      end
      if (sample_valid) begin
        shadow_reg <= duty_new;
      end
    end
  end

  // Channel 0 is the high side (raw), channel 1 the low side (~raw).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dead
      logic [DCW-1:0] dcnt_reg;
      logic           out_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          dcnt_reg <= '0;
          out_reg  <= 1'b0;
        end else if (!enable) begin
          dcnt_reg <= '0;
          out_reg  <= 1'b0;
        end else begin
          out_reg <= drive[gi] && (dcnt_reg >= DEAD_C);
          if (!drive[gi]) begin
            dcnt_reg <= '0;
          end else if (dcnt_reg != DEAD_C) begin
            dcnt_reg <= dcnt_reg + 1'b1;
          end
        end
      end

      assign out_vec[gi] = out_reg;
    end
  endgenerate

  assign sample_taken = taken_reg;
  assign overrun      = overrun_reg;
  assign period_start = period_start_reg;
  assign pwm_hi       = out_vec[0];
  assign pwm_lo       = out_vec[1];

endmodule

// File: tb/tb_dds_pwm_dac.sv
// Directed bench for dds_pwm_dac: duty conversion, double buffering, dead time,
// reset and enable behaviour, with per-period output cycle counts.
module tb_dds_pwm_dac;
  localparam int DW   = 20;
  localparam int PW   = 8;
  localparam int DEAD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_taken;
  logic          overrun;
  logic          period_start;
  logic          pwm_hi;
  logic          pwm_lo;

  int checks = 0;
  int errors = 0;
  int n_taken = 0;
  int n_ovr = 0;

  dds_pwm_dac #(.DW(DW), .PW(PW), .DEAD(DEAD)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_taken (sample_taken),
    .overrun      (overrun),
    .period_start (period_start),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock and sample just after the edge; tally the strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sample_taken === 1'b1) n_taken++;
    if (overrun === 1'b1) n_ovr++;
  endtask

  task automatic pulse(input logic [DW-1:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_ps(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (period_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // Count output states over 256 consecutive cycles.
  task automatic measure(input string tag, input int exp_hi, input int exp_lo, input int exp_gap);
    int hi = 0;
    int lo = 0;
    int gap = 0;
    int both = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_hi === 1'b1) hi++;
      if (pwm_lo === 1'b1) lo++;
      if (pwm_hi === 1'b0 && pwm_lo === 1'b0) gap++;
      if (pwm_hi === 1'b1 && pwm_lo === 1'b1) both++;
      tick();
    end
    chk({tag, "_hi"}, 32'(hi), 32'(exp_hi));
    chk({tag, "_lo"}, 32'(lo), 32'(exp_lo));
    chk({tag, "_gap"}, 32'(gap), 32'(exp_gap));
    chk({tag, "_both"}, 32'(both), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_hi", 32'(pwm_hi), 32'd0);
    chk("rst_lo", 32'(pwm_lo), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd0);
    chk("rst_taken", 32'(sample_taken), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);

    reset  = 1'b1;
    enable = 1'b1;
    tick();
    chk("start_ps", 32'(period_start), 32'd1);
    measure("mid_default", 126, 126, 4);

    // Reset in the middle of a high pulse.
    repeat (5) tick();
    chk("pre_rst_hi", 32'(pwm_hi), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_hi", 32'(pwm_hi), 32'd0);
    chk("async_rst_lo", 32'(pwm_lo), 32'd0);
    chk("async_rst_ps", 32'(period_start), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    chk("restart_ps", 32'(period_start), 32'd1);
    chk("restart_hi", 32'(pwm_hi), 32'd0);

    // Sample 0 -> duty 128.
    n_taken = 0;
    n_ovr   = 0;
    pulse(20'h00000);
    wait_ps("ps_s0");
    measure("s0", 126, 126, 4);
    chk("s0_taken", 32'(n_taken), 32'd1);
    chk("s0_ovr", 32'(n_ovr), 32'd0);

    // Full-scale positive -> duty 255.
    n_taken = 0;
    pulse(20'h7FFFF);
    wait_ps("ps_smax");
    measure("smax", 253, 0, 3);
    chk("smax_taken", 32'(n_taken), 32'd1);

    // Full-scale negative -> duty 0.
    n_taken = 0;
    pulse(20'h80000);
    wait_ps("ps_smin");
    measure("smin_a", 0, 255, 1);
    measure("smin_b", 0, 256, 0);
    chk("smin_taken", 32'(n_taken), 32'd1);

    // Two valids in one period: latest wins, one overrun.
    n_taken = 0;
    n_ovr   = 0;
    pulse(20'h00000);
    tick();
    pulse(20'h7FFFF);
    wait_ps("ps_dbl");
    measure("dbl", 253, 0, 3);
    chk("dbl_ovr", 32'(n_ovr), 32'd1);
    chk("dbl_taken", 32'(n_taken), 32'd1);

    // Valid on the last count with nothing pending waits a full period.
    repeat (254) tick();
    n_taken = 0;
    pulse(20'h80000);
    tick();
    chk("late_taken_now", 32'(n_taken), 32'd0);
    measure("late_a", 253, 0, 3);
    chk("late_taken", 32'(n_taken), 32'd1);
    measure("late_b", 0, 255, 1);

    // Valid coinciding with a transfer: old shadow applied, new one pends, no overrun.
    n_taken = 0;
    n_ovr   = 0;
    pulse(20'h00000);
    repeat (253) tick();
    pulse(20'h7FFFF);
    tick();
    chk("sim_ovr", 32'(n_ovr), 32'd0);
    chk("sim_taken", 32'(n_taken), 32'd1);
    measure("sim_a", 126, 126, 4);
    chk("sim_taken2", 32'(n_taken), 32'd2);
    measure("sim_b", 253, 0, 3);
    chk("sim_ovr2", 32'(n_ovr), 32'd0);

    // Disable mid-pulse.
    repeat (3) tick();
    chk("pre_dis_hi", 32'(pwm_hi), 32'd1);
    enable = 1'b0;
    tick();
    chk("dis_hi", 32'(pwm_hi), 32'd0);
    chk("dis_lo", 32'(pwm_lo), 32'd0);
    repeat (3) tick();
    chk("dis_lo_hold", 32'(pwm_lo), 32'd0);
    chk("dis_ps", 32'(period_start), 32'd0);
    enable = 1'b1;
    tick();
    chk("reen_ps", 32'(period_start), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
